// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbiter: bus word, RAM status and grant FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-port signals seen by the arbiter.
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Arbiter side: owns the RAM port and the cache wait/load returns.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment side: the two caches plus the RAM.
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_watchdog.sv
// Counts granted cycles without RAM ACCESS; pulses timeout and latches a sticky error.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_active,
    input  logic i_done,
    output logic o_timeout,
    output logic o_err
);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] r_wd_cnt;
    logic          r_err;

    // Fires in the TIMEOUT-th stalled grant cycle so the FSM leaves on that edge.
    assign o_timeout = i_active && !i_done && (r_wd_cnt == WW'(TIMEOUT - 1));
    assign o_err     = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (!i_active || i_done || o_timeout) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (o_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port; dcache first, icache anti-starvation.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.master bus,
    output logic                err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_next;
    logic          w_dreq;
    logic          w_force_i;
    logic          w_done;
    logic          w_active;
    logic          w_timeout;

    assign w_dreq    = bus.dREN | bus.dWEN;
    assign w_force_i = bus.iREN && (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_done    = (bus.ramstate == ACCESS);
    assign w_active  = (r_state != IDLE);

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_active  (w_active),
        .i_done    (w_done),
        .o_timeout (w_timeout),
        .o_err     (err)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves an output unassigned and infers a latch.
        w_next_state = r_state;
        w_starve_next = r_starve_cnt;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (r_state)
            IDLE: begin
                if (w_dreq && !w_force_i) begin
                    w_next_state = DGNT;
                end else if (bus.iREN) begin
                    w_next_state = IGNT;
                end
            end

            DGNT: begin
                if (!w_dreq) begin
                    w_next_state = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (w_done) begin
                        bus.dwait    = 1'b0;
                        w_next_state = IDLE;
                        if (!bus.iREN) begin
                            w_starve_next = '0;
                        end else if (r_starve_cnt != SW'(STARVE_LIMIT)) begin
                            w_starve_next = r_starve_cnt + 1'b1;
                        end
                    end
                end
            end

            IGNT: begin
                if (!bus.iREN) begin
                    w_next_state = IDLE;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (w_done) begin
                        bus.iwait     = 1'b0;
                        w_next_state  = IDLE;
                        w_starve_next = '0;
                    end
                end
            end

            default: w_next_state = IDLE;
        endcase

        // A stuck transaction is abandoned unacknowledged and re-arbitrated.
        if (w_timeout) begin
            w_next_state = IDLE;
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the icache and dcache. Arbitrates their single-word RAM requests onto the one shared RAM port and returns load data and wait status to each cache.
- Uses a registered grant FSM: dcache has priority, and a starvation counter guarantees icache progress.
- A watchdog flags RAM transactions that never complete.

Parameters:
- STARVE_LIMIT, 4: consecutive dcache grants with iREN pending before icache is forced next.
- TIMEOUT, 255: cycles in a grant state without ramstate==ACCESS before err is set.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iload  out  32  instruction word to icache.
- iwait  out  1  high = icache must hold request.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dload  out  32  data word to dcache.
- dwait  out  1  high = dcache must hold request.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset: asynchronous and active-low. Reset gives state=IDLE, starve_cnt=0, wd_cnt=0, err=0.
- Outputs during and after reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iload and dload are always driven by ramload (combinational passthrough). They are valid only in the cycle where the matching wait is low.
- States: IDLE, IGNT, DGNT.
- IDLE:
  - No RAM enables; both waits high.
  - Next state is DGNT if (dREN|dWEN) and not (iREN && starve_cnt==STARVE_LIMIT).
  - Otherwise next state is IGNT if iREN; otherwise stay in IDLE.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN. Write wins if both are asserted.
  - When ramstate==ACCESS: dwait=0 in that same cycle (combinational), next state IDLE.
  - On completion, starve_cnt increments if iREN is high (saturating at STARVE_LIMIT), else it clears.
- IGNT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - When ramstate==ACCESS: iwait=0 in that same cycle, next state IDLE, starve_cnt cleared.
- Latency: request seen in IDLE at edge N, RAM driven from N+1, and the earliest wait-low is cycle N+1 (RAM returning ACCESS immediately). Consecutive grants are separated by one IDLE cycle.
- The ungranted cache always sees wait=1.
- BUSY, FREE or ERROR while granted: hold the grant with all outputs stable.
- Request withdrawn while granted (dREN=dWEN=0 in DGNT, or iREN=0 in IGNT): drop RAM enables that cycle, return to IDLE next edge, no wait-low pulse.
- Watchdog:
  - wd_cnt increments each grant cycle without ACCESS and clears on ACCESS or in IDLE.
  - On reaching TIMEOUT, set err=1 (sticky until nRST) and force state to IDLE.
  - The requester is not acknowledged and re-arbitrates.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_LIMIT: dcache wins.
- Reset asserted mid-grant: enables drop asynchronously and nothing is acknowledged.

Decomposition:
- cpu_types_pkg holds: word_t (32b), ramstate_t enum (FREE, BUSY, ACCESS, ERROR), and arbiter state enum arb_state_t.
- Sub-module arb_watchdog: wd_cnt and sticky err. Inputs: active and done; output: timeout pulse.
- The rest is one FSM plus output mux.

Test Plan:
- I-only read: iREN=1, iaddr=0x40, RAM returns BUSY for 2 cycles then ACCESS with 0x8C220004.
  - Required: ramREN=1, ramaddr=0x40 for 3 cycles; iwait low only in the ACCESS cycle; iload=0x8C220004; then IDLE.
- Simultaneous requests: iREN=1 (0x10) and dREN=1 (0x200), RAM ACCESS on first cycle.
  - Required: dwait low first; one IDLE cycle; then icache served with iwait low.
- Starvation: dWEN held continuously with new addresses and iREN=1 held, STARVE_LIMIT=4.
  - Required: exactly 4 dcache grants, then an IGNT, then dcache resumes.
- Write priority: dREN=dWEN=1, daddr=0x80, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS.
- Timeout: iREN=1 with ramstate stuck at BUSY, TIMEOUT=255.
  - Required: err rises after 255 grant cycles; iwait never low; FSM re-grants from IDLE; err stays 1 until nRST.
- Mid-grant reset and withdrawal:
  - nRST pulsed low during DGNT: immediately ramWEN=0, dwait=1, err=0.
  - Separately, iREN dropped during BUSY: ramREN=0 that cycle, IDLE next.
